st506_seek_controller: RTL and testbench
========================================

Name: st506_seek_controller

Overview:
Upstream seek sequencer for the ST-506 drive interface. It accepts seek and recalibrate commands from the command FSM and generates timed step_pulse/step_direction levels that the interface inverts onto the 34-pin cable. It consumes the interface's synchronised status (seek_complete, at_track00, drive_ready), tracks the current cylinder, and reports done/error to the FSM.

Parameters:
CYL_W, 11, cylinder number width (up to 2048 cylinders)
DIR_SETUP_CYC, 300, direction setup before the first pulse (1 us @ 300 MHz)
STEP_PULSE_CYC, 3000, step_pulse high time (10 us)
STEP_GAP_CYC, 9000, step_pulse low time between pulses (30 us, buffered-step rate)
SC_BLANK_CYC, 64, wait after the last pulse before seek_complete is sampled
SEEK_TIMEOUT_CYC, 300000000, maximum wait for seek_complete (1 s); 32-bit
RECAL_MAX_STEPS, 2047, outward step limit when searching for track 0

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_seek  in  1  single-cycle request to seek to target_cyl
cmd_recal  in  1  single-cycle request to step out to track 0
target_cyl  in  CYL_W  destination cylinder, sampled with cmd_seek
seek_complete  in  1  active-high, already synchronised
at_track00  in  1  active-high, already synchronised
drive_ready  in  1  active-high, already synchronised
step_pulse  out  1  active-high step request level
step_direction  out  1  1 = in (toward spindle), 0 = out
busy  out  1  command in progress
done  out  1  single-cycle completion strobe
error  out  1  last command failed; valid when done is high, held afterwards
err_code  out  3  0 none, 1 NOT_READY, 2 NOT_CAL, 3 SEEK_TIMEOUT, 4 TRK0_NOT_FOUND
current_cyl  out  CYL_W  tracked head position
cyl_valid  out  1  current_cyl is trustworthy

Behaviour:
- Reset values: all outputs 0, state IDLE. step_pulse is forced low on reset assertion.
- FSM states: IDLE, DIR_SETUP, PULSE, GAP, SETTLE, FINISH. One shared 32-bit down-counter provides all timing. A separate CYL_W-bit register counts remaining steps (seek) or steps issued (recal).
- IDLE:
  - Commands are accepted only in IDLE; commands that arrive while busy are ignored.
  - cmd_recal has priority if both commands are asserted in the same cycle.
  - Acceptance clears error/err_code and sets busy on the next edge.
- Seek acceptance checks, in priority order:
  - drive_ready=0 → FINISH with NOT_READY.
  - cyl_valid=0 → FINISH with NOT_CAL.
  - target_cyl==current_cyl → SETTLE (no pulses; blanking still applies).
  - Otherwise: step_direction = (target>current), remaining = |target-current| (unsigned, CYL_W bits, no wrap), then DIR_SETUP.
- Recal acceptance:
  - drive_ready=0 → NOT_READY.
  - Otherwise step_direction=0 and cyl_valid=0.
  - If at_track00=1 → SETTLE; otherwise DIR_SETUP.
- DIR_SETUP: hold for DIR_SETUP_CYC cycles, then PULSE.
- PULSE:
  - step_pulse=1 for exactly STEP_PULSE_CYC cycles.
  - On exit, current_cyl is updated by ±1 per direction (saturating at 0 when stepping out), and remaining is decremented (seek) or issued is incremented (recal).
- GAP: step_pulse=0 for STEP_GAP_CYC cycles, then:
  - Seek: remaining>0 → PULSE; else SETTLE.
  - Recal: at_track00=1 → SETTLE with current_cyl=0; issued==RECAL_MAX_STEPS → FINISH with TRK0_NOT_FOUND; else PULSE.
- SETTLE:
  - Ignore seek_complete for SC_BLANK_CYC cycles.
  - Then wait for seek_complete=1 → FINISH (success).
  - If SEEK_TIMEOUT_CYC cycles pass first → FINISH with SEEK_TIMEOUT and cyl_valid=0.
  - Successful recal sets cyl_valid=1 and current_cyl=0.
- FINISH: assert done for one cycle with error/err_code valid, busy=0 in the same cycle, then IDLE.
- Abort: drive_ready=0 in DIR_SETUP, PULSE, GAP or SETTLE → step_pulse=0 on the next edge, cyl_valid=0, FINISH with NOT_READY. A pulse cut short does not update current_cyl.
- step_direction stays stable from acceptance through FINISH and holds its last value in IDLE.
- Latency: a no-motion seek gives done at acceptance + SC_BLANK_CYC + (cycles until seek_complete) + 2.

Decomposition:
- Package st506_seek_pkg holds: state encoding, err_code constants, and default timing constants.
- One sub-module, st506_cycle_timer: a loadable 32-bit down-counter with a zero flag, shared by all timed states.

Test Plan:
- Recal from cylinder 5 (track00 model asserts after the 5th pulse) → exactly 5 pulses, each 3000 cycles high with ≥9000 cycles low, direction 0; done with err_code 0, current_cyl=0, cyl_valid=1.
- After recal, seek to 100, then seek to 40 → 100 pulses with direction 1, then 60 pulses with direction 0; current_cyl reads 100, then 40.
- cmd_seek before any recal → done 1 cycle later with err_code 2, zero pulses; cmd_seek and cmd_recal in the same cycle → recal runs.
- Drive model never reasserts seek_complete (SEEK_TIMEOUT_CYC reduced to 1000) → err_code 3, cyl_valid=0.
- drive_ready dropped mid-PULSE during seek 0→10 → step_pulse low next cycle, err_code 1, cyl_valid=0.
- at_track00 never asserted (RECAL_MAX_STEPS=16) → exactly 16 pulses, err_code 4; async reset asserted mid-PULSE → all outputs 0 immediately.

Source files
------------

// File: rtl/st506_seek_pkg.sv
// Shared types and default timing for the ST-506 seek sequencer.
// Timing defaults assume a 300 MHz system clock.
package st506_seek_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_DIR_SETUP = 3'd1,
      ST_PULSE     = 3'd2,
      ST_GAP       = 3'd3,
      ST_SETTLE    = 3'd4,
      ST_FINISH    = 3'd5
   } seek_state_e;

   typedef enum logic [2:0] {
      ERR_NONE           = 3'd0,
      ERR_NOT_READY      = 3'd1,
      ERR_NOT_CAL        = 3'd2,
      ERR_SEEK_TIMEOUT   = 3'd3,
      ERR_TRK0_NOT_FOUND = 3'd4
   } seek_err_e;

   localparam int unsigned TIMER_W              = 32;
   localparam int unsigned DEF_CYL_W            = 11;
   localparam int unsigned DEF_DIR_SETUP_CYC    = 300;
   localparam int unsigned DEF_STEP_PULSE_CYC   = 3000;
   localparam int unsigned DEF_STEP_GAP_CYC     = 9000;
   localparam int unsigned DEF_SC_BLANK_CYC     = 64;
   localparam int unsigned DEF_SEEK_TIMEOUT_CYC = 300000000;
   localparam int unsigned DEF_RECAL_MAX_STEPS  = 2047;

   // A state that must last N cycles loads N-1: the exit decision is taken on the zero cycle.
   function automatic logic [TIMER_W-1:0] timer_span(input int unsigned cycles);
      return (cycles == 0) ? '0 : TIMER_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/st506_cycle_timer.sv
// Loadable down-counter shared by every timed state of the seek sequencer.
module st506_cycle_timer
   import st506_seek_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] load_val_i,
   output logic               zero_o
);

   logic [TIMER_W-1:0] count_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (count_q != '0) begin
         count_q <= count_q - TIMER_W'(1);
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/st506_seek_controller.sv
// Seek/recalibrate sequencer: generates timed step pulses, tracks the head cylinder
// and reports done/error to the command FSM.
module st506_seek_controller
   import st506_seek_pkg::*;
#(
   parameter int unsigned CYL_W            = DEF_CYL_W,
   parameter int unsigned DIR_SETUP_CYC    = DEF_DIR_SETUP_CYC,
   parameter int unsigned STEP_PULSE_CYC   = DEF_STEP_PULSE_CYC,
   parameter int unsigned STEP_GAP_CYC     = DEF_STEP_GAP_CYC,
   parameter int unsigned SC_BLANK_CYC     = DEF_SC_BLANK_CYC,
   parameter int unsigned SEEK_TIMEOUT_CYC = DEF_SEEK_TIMEOUT_CYC,
   parameter int unsigned RECAL_MAX_STEPS  = DEF_RECAL_MAX_STEPS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_seek,
   input  logic             cmd_recal,
   input  logic [CYL_W-1:0] target_cyl,
   input  logic             seek_complete,
   input  logic             at_track00,
   input  logic             drive_ready,
   output logic             step_pulse,
   output logic             step_direction,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [2:0]       err_code,
   output logic [CYL_W-1:0] current_cyl,
   output logic             cyl_valid
);

   seek_state_e        state_q, state_d;
   seek_err_e          err_code_q, err_code_d;
   logic [CYL_W-1:0]   cyl_q, cyl_d;
   logic [CYL_W-1:0]   steps_q, steps_d;
   logic               dir_q, dir_d;
   logic               cyl_valid_q, cyl_valid_d;
   logic               recal_q, recal_d;
   logic               blank_q, blank_d;
   logic               error_q, error_d;
   logic               step_pulse_q, busy_q, done_q;
   logic               tmr_load, tmr_zero, abort;
   logic [TIMER_W-1:0] tmr_val;

   st506_cycle_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   assign abort = !drive_ready &&
                  (state_q inside {ST_DIR_SETUP, ST_PULSE, ST_GAP, ST_SETTLE});

   always_comb begin
      // NOTE: every next-state value defaults to its register first, so no path infers a latch.
      state_d     = state_q;
      err_code_d  = err_code_q;
      error_d     = error_q;
      cyl_d       = cyl_q;
      steps_d     = steps_q;
      dir_d       = dir_q;
      cyl_valid_d = cyl_valid_q;
      recal_d     = recal_q;
      blank_d     = blank_q;
      tmr_load    = 1'b0;
      tmr_val     = '0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_recal || cmd_seek) begin
               error_d    = 1'b0;
               err_code_d = ERR_NONE;
               recal_d    = cmd_recal;
               tmr_load   = 1'b1;
               tmr_val    = timer_span(DIR_SETUP_CYC);
               if (!drive_ready) begin
                  state_d    = ST_FINISH;
                  error_d    = 1'b1;
                  err_code_d = ERR_NOT_READY;
               end else if (cmd_recal) begin
                  dir_d       = 1'b0;
                  cyl_valid_d = 1'b0;
                  steps_d     = '0;
                  state_d     = at_track00 ? ST_SETTLE : ST_DIR_SETUP;
               end else if (!cyl_valid_q) begin
                  state_d    = ST_FINISH;
                  error_d    = 1'b1;
                  err_code_d = ERR_NOT_CAL;
               end else if (target_cyl == cyl_q) begin
                  state_d = ST_SETTLE;
               end else begin
                  dir_d   = (target_cyl > cyl_q);
                  steps_d = (target_cyl > cyl_q) ? target_cyl - cyl_q : cyl_q - target_cyl;
                  state_d = ST_DIR_SETUP;
               end
               if (state_d == ST_SETTLE) begin
                  blank_d = 1'b1;
                  tmr_val = timer_span(SC_BLANK_CYC);
               end
            end
         end
         ST_DIR_SETUP: begin
            if (tmr_zero) begin
               state_d  = ST_PULSE;
               tmr_load = 1'b1;
               tmr_val  = timer_span(STEP_PULSE_CYC);
            end
         end
         ST_PULSE: begin
            if (tmr_zero) begin
               state_d  = ST_GAP;
               tmr_load = 1'b1;
               tmr_val  = timer_span(STEP_GAP_CYC);
               steps_d  = recal_q ? steps_q + CYL_W'(1) : steps_q - CYL_W'(1);
               if (dir_q) begin
                  cyl_d = cyl_q + CYL_W'(1);
               end else if (cyl_q != '0) begin
                  cyl_d = cyl_q - CYL_W'(1);
               end
            end
         end
         ST_GAP: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = timer_span(STEP_PULSE_CYC);
               state_d  = ST_PULSE;
               if (recal_q && at_track00) begin
                  state_d = ST_SETTLE;
                  cyl_d   = '0;
               end else if (recal_q && steps_q == CYL_W'(RECAL_MAX_STEPS)) begin
                  state_d    = ST_FINISH;
                  error_d    = 1'b1;
                  err_code_d = ERR_TRK0_NOT_FOUND;
               end else if (!recal_q && steps_q == '0) begin
                  state_d = ST_SETTLE;
               end
               if (state_d == ST_SETTLE) begin
                  blank_d = 1'b1;
                  tmr_val = timer_span(SC_BLANK_CYC);
               end
            end
         end
         ST_SETTLE: begin
            // seek_complete is meaningless while the drive is still latching the last step.
            if (blank_q) begin
               if (tmr_zero) begin
                  blank_d  = 1'b0;
                  tmr_load = 1'b1;
                  tmr_val  = timer_span(SEEK_TIMEOUT_CYC);
               end
            end else if (seek_complete) begin
               state_d = ST_FINISH;
               if (recal_q) begin
                  cyl_valid_d = 1'b1;
                  cyl_d       = '0;
               end
            end else if (tmr_zero) begin
               state_d     = ST_FINISH;
               error_d     = 1'b1;
               err_code_d  = ERR_SEEK_TIMEOUT;
               cyl_valid_d = 1'b0;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      // Losing the drive mid-command wins over everything; a truncated pulse never counts.
      if (abort) begin
         state_d     = ST_FINISH;
         error_d     = 1'b1;
         err_code_d  = ERR_NOT_READY;
         cyl_valid_d = 1'b0;
         cyl_d       = cyl_q;
         steps_d     = steps_q;
         tmr_load    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         err_code_q   <= ERR_NONE;
         error_q      <= 1'b0;
         cyl_q        <= '0;
         steps_q      <= '0;
         dir_q        <= 1'b0;
         cyl_valid_q  <= 1'b0;
         recal_q      <= 1'b0;
         blank_q      <= 1'b0;
         step_pulse_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         err_code_q   <= err_code_d;
         error_q      <= error_d;
         cyl_q        <= cyl_d;
         steps_q      <= steps_d;
         dir_q        <= dir_d;
         cyl_valid_q  <= cyl_valid_d;
         recal_q      <= recal_d;
         blank_q      <= blank_d;
         step_pulse_q <= (state_d == ST_PULSE);
         busy_q       <= (state_d inside {ST_DIR_SETUP, ST_PULSE, ST_GAP, ST_SETTLE});
         done_q       <= (state_d == ST_FINISH);
      end
   end

   assign step_pulse     = step_pulse_q;
   assign step_direction = dir_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = error_q;
   assign err_code       = err_code_q;
   assign current_cyl    = cyl_q;
   assign cyl_valid      = cyl_valid_q;

endmodule

// File: tb/tb_st506_seek_controller.sv
// Directed bench for st506_seek_controller with shortened timing and a simple drive model.
module tb_st506_seek_controller;

   localparam int CYL_W = 11;
   localparam int DIR   = 3;
   localparam int PUL   = 4;
   localparam int GAP   = 6;
   localparam int BLANK = 5;
   localparam int TMO   = 1000;
   localparam int MAXS  = 16;

   logic clk = 1'b0;
   logic reset, cmd_seek, cmd_recal, seek_complete, drive_ready;
   logic at_track00 = 1'b0;
   logic [CYL_W-1:0] target_cyl;
   logic step_pulse, step_direction, busy, done, error, cyl_valid;
   logic [2:0] err_code;
   logic [CYL_W-1:0] current_cyl;

   int total = 0;
   int bad   = 0;

   // Drive model state: the initial block owns the *_base/enable knobs, the monitor owns the counters.
   int   phys_base = 5;
   bit   trk_en    = 1'b1;
   logic exp_dir   = 1'b0;
   int   net_moves = 0;
   int   pulse_cnt = 0, dir_bad = 0, width_bad = 0, gap_bad = 0;
   int   hi_cnt = 0, low_cnt = 0;
   bit   had_fall = 1'b0;
   logic prev_sp  = 1'b0;

   always #5 clk = ~clk;

   st506_seek_controller #(
      .CYL_W(CYL_W), .DIR_SETUP_CYC(DIR), .STEP_PULSE_CYC(PUL), .STEP_GAP_CYC(GAP),
      .SC_BLANK_CYC(BLANK), .SEEK_TIMEOUT_CYC(TMO), .RECAL_MAX_STEPS(MAXS)
   ) dut (
      .clk(clk), .reset(reset), .cmd_seek(cmd_seek), .cmd_recal(cmd_recal),
      .target_cyl(target_cyl), .seek_complete(seek_complete), .at_track00(at_track00),
      .drive_ready(drive_ready), .step_pulse(step_pulse), .step_direction(step_direction),
      .busy(busy), .done(done), .error(error), .err_code(err_code),
      .current_cyl(current_cyl), .cyl_valid(cyl_valid)
   );

   always @(negedge clk) begin
      if (step_pulse === 1'b1 && prev_sp !== 1'b1) begin
         pulse_cnt++;
         if (step_direction !== exp_dir) dir_bad++;
         if (had_fall && low_cnt < GAP) gap_bad++;
         net_moves += (step_direction === 1'b1) ? 1 : -1;
         hi_cnt = 1;
      end else if (step_pulse === 1'b1) begin
         hi_cnt++;
      end else if (prev_sp === 1'b1) begin
         if (hi_cnt != PUL) width_bad++;
         had_fall = 1'b1;
         low_cnt  = 1;
      end else begin
         low_cnt++;
      end
      if (busy !== 1'b1 && step_pulse !== 1'b1) had_fall = 1'b0;
      prev_sp    = step_pulse;
      at_track00 = trk_en && (phys_base + net_moves == 0);
   end

   task automatic issue(input bit s, input bit r, input logic [CYL_W-1:0] t);
      cmd_seek = s; cmd_recal = r; target_cyl = t;
      @(negedge clk);
      cmd_seek = 1'b0; cmd_recal = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int n, output bit ok);
      n = 0; ok = 1'b0;
      while (n < budget) begin
         if (done === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; cmd_seek = 1'b0; cmd_recal = 1'b0; target_cyl = '0;
      seek_complete = 1'b1; drive_ready = 1'b1;
      repeat (3) @(negedge clk);
      total++; if ({step_pulse, step_direction, busy, done, error} !== 5'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=00000", {step_pulse, step_direction, busy, done, error}); end
      total++; if (err_code !== 3'd0) begin bad++; $display("FAIL reset_err_code got=%0d exp=0", err_code); end
      total++; if ({cyl_valid, current_cyl} !== '0) begin bad++; $display("FAIL reset_cyl got=%0d/%b exp=0/0", current_cyl, cyl_valid); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_seek_uncal;
      int p0 = pulse_cnt;
      issue(1'b1, 1'b0, 11'd3);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL uncal_done got=%b exp=1", done); end
      total++; if (err_code !== 3'd2) begin bad++; $display("FAIL uncal_err_code got=%0d exp=2", err_code); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL uncal_busy got=%b exp=0", busy); end
      @(negedge clk);
      total++; if ({done, error} !== 2'b01) begin bad++; $display("FAIL uncal_hold got=%b exp=01", {done, error}); end
      total++; if (pulse_cnt - p0 != 0) begin bad++; $display("FAIL uncal_pulses got=%0d exp=0", pulse_cnt - p0); end
   endtask

   task automatic test_recal_priority;
      int p0 = pulse_cnt, d0 = dir_bad, w0 = width_bad, g0 = gap_bad, n;
      bit ok;
      exp_dir = 1'b0;
      issue(1'b1, 1'b1, 11'd50);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL recal_busy got=%b exp=1", busy); end
      wait_done(2000, n, ok);
      total++; if (!ok) begin bad++; $display("FAIL recal_done got=timeout exp=done"); end
      total++; if ({error, err_code} !== 4'd0) begin bad++; $display("FAIL recal_err got=%b/%0d exp=0/0", error, err_code); end
      total++; if ({cyl_valid, current_cyl} !== {1'b1, 11'd0}) begin bad++; $display("FAIL recal_cyl got=%0d/%b exp=0/1", current_cyl, cyl_valid); end
      total++; if (pulse_cnt - p0 != 5) begin bad++; $display("FAIL recal_pulses got=%0d exp=5", pulse_cnt - p0); end
      total++; if (dir_bad - d0 != 0) begin bad++; $display("FAIL recal_dir got=%0d exp=0 wrong", dir_bad - d0); end
      total++; if (width_bad - w0 != 0) begin bad++; $display("FAIL recal_width got=%0d exp=0 wrong", width_bad - w0); end
      total++; if (gap_bad - g0 != 0) begin bad++; $display("FAIL recal_gap got=%0d exp=0 short", gap_bad - g0); end
      @(negedge clk);
   endtask

   task automatic test_no_motion_latency;
      int p0 = pulse_cnt, n;
      bit ok;
      issue(1'b1, 1'b0, 11'd0);
      wait_done(100, n, ok);
      // Command cycle c0; done lands in cycle c0+BLANK+2, which is BLANK+1 negedges after issue returns.
      total++; if (!ok || n != BLANK + 1) begin bad++; $display("FAIL nomotion_latency got=%0d ok=%b exp=%0d", n, ok, BLANK + 1); end
      total++; if (err_code !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL nomotion_status got=%0d/%b exp=0/0", err_code, busy); end
      total++; if (pulse_cnt - p0 != 0) begin bad++; $display("FAIL nomotion_pulses got=%0d exp=0", pulse_cnt - p0); end
      @(negedge clk);
   endtask

   task automatic test_seek_in_out;
      int p0 = pulse_cnt, d0 = dir_bad, w0 = width_bad, g0 = gap_bad, n;
      bit ok;
      exp_dir = 1'b1;
      issue(1'b1, 1'b0, 11'd100);
      repeat (50) @(negedge clk);
      cmd_recal = 1'b1;
      @(negedge clk);
      cmd_recal = 1'b0;
      wait_done(5000, n, ok);
      total++; if (!ok) begin bad++; $display("FAIL seek100_done got=timeout exp=done"); end
      total++; if (pulse_cnt - p0 != 100) begin bad++; $display("FAIL seek100_pulses got=%0d exp=100", pulse_cnt - p0); end
      total++; if (dir_bad - d0 != 0) begin bad++; $display("FAIL seek100_dir got=%0d exp=0 wrong", dir_bad - d0); end
      total++; if (width_bad - w0 != 0 || gap_bad - g0 != 0) begin bad++; $display("FAIL seek100_timing got=%0d/%0d exp=0/0", width_bad - w0, gap_bad - g0); end
      total++; if (current_cyl !== 11'd100 || err_code !== 3'd0) begin bad++; $display("FAIL seek100_cyl got=%0d/%0d exp=100/0", current_cyl, err_code); end
      @(negedge clk);
      p0 = pulse_cnt; d0 = dir_bad;
      exp_dir = 1'b0;
      issue(1'b1, 1'b0, 11'd40);
      wait_done(5000, n, ok);
      total++; if (!ok) begin bad++; $display("FAIL seek40_done got=timeout exp=done"); end
      total++; if (pulse_cnt - p0 != 60) begin bad++; $display("FAIL seek40_pulses got=%0d exp=60", pulse_cnt - p0); end
      total++; if (dir_bad - d0 != 0) begin bad++; $display("FAIL seek40_dir got=%0d exp=0 wrong", dir_bad - d0); end
      total++; if (current_cyl !== 11'd40 || cyl_valid !== 1'b1) begin bad++; $display("FAIL seek40_cyl got=%0d/%b exp=40/1", current_cyl, cyl_valid); end
      @(negedge clk);
   endtask

   task automatic test_timeout;
      int p0 = pulse_cnt, n;
      bit ok;
      seek_complete = 1'b0;
      exp_dir = 1'b1;
      issue(1'b1, 1'b0, 11'd45);
      wait_done(4000, n, ok);
      total++; if (!ok) begin bad++; $display("FAIL timeout_done got=timeout exp=done"); end
      total++; if ({error, err_code} !== {1'b1, 3'd3}) begin bad++; $display("FAIL timeout_err got=%b/%0d exp=1/3", error, err_code); end
      total++; if (cyl_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL timeout_valid got=%b/%b exp=0/0", cyl_valid, busy); end
      total++; if (pulse_cnt - p0 != 5) begin bad++; $display("FAIL timeout_pulses got=%0d exp=5", pulse_cnt - p0); end
      seek_complete = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_trk0_missing;
      int p0 = pulse_cnt, d0 = dir_bad, n;
      bit ok;
      trk_en = 1'b0;
      exp_dir = 1'b0;
      issue(1'b0, 1'b1, 11'd0);
      wait_done(1000, n, ok);
      total++; if (!ok) begin bad++; $display("FAIL trk0_done got=timeout exp=done"); end
      total++; if (pulse_cnt - p0 != MAXS) begin bad++; $display("FAIL trk0_pulses got=%0d exp=%0d", pulse_cnt - p0, MAXS); end
      total++; if ({error, err_code} !== {1'b1, 3'd4}) begin bad++; $display("FAIL trk0_err got=%b/%0d exp=1/4", error, err_code); end
      total++; if (cyl_valid !== 1'b0 || dir_bad - d0 != 0) begin bad++; $display("FAIL trk0_state got=%b/%0d exp=0/0", cyl_valid, dir_bad - d0); end
      trk_en = 1'b1;
      @(negedge clk);
   endtask

   task automatic recal_from(input int cyl, input string tag);
      int n;
      bit ok;
      phys_base = cyl - net_moves;
      exp_dir = 1'b0;
      @(negedge clk);
      issue(1'b0, 1'b1, 11'd0);
      wait_done(2000, n, ok);
      total++; if (!ok || err_code !== 3'd0 || cyl_valid !== 1'b1) begin bad++; $display("FAIL %s_recal got=%b/%0d/%b exp=1/0/1", tag, ok, err_code, cyl_valid); end
      @(negedge clk);
   endtask

   task automatic test_abort;
      int p0, n = 0;
      recal_from(2, "abort");
      p0 = pulse_cnt;
      exp_dir = 1'b1;
      issue(1'b1, 1'b0, 11'd10);
      while (!(pulse_cnt - p0 >= 3 && step_pulse === 1'b1) && n < 500) begin @(negedge clk); n++; end
      total++; if (n >= 500) begin bad++; $display("FAIL abort_reach got=timeout exp=third_pulse"); end
      drive_ready = 1'b0;
      @(negedge clk);
      total++; if (step_pulse !== 1'b0) begin bad++; $display("FAIL abort_pulse got=%b exp=0", step_pulse); end
      total++; if ({done, error, err_code} !== {2'b11, 3'd1}) begin bad++; $display("FAIL abort_err got=%b/%b/%0d exp=1/1/1", done, error, err_code); end
      total++; if ({cyl_valid, current_cyl} !== {1'b0, 11'd2}) begin bad++; $display("FAIL abort_cyl got=%0d/%b exp=2/0", current_cyl, cyl_valid); end
      drive_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_pulse;
      int n = 0;
      recal_from(3, "rstmid");
      exp_dir = 1'b1;
      issue(1'b1, 1'b0, 11'd4);
      while (step_pulse !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      total++; if (n >= 200) begin bad++; $display("FAIL rstmid_reach got=timeout exp=pulse"); end
      #1 reset = 1'b1;
      #1;
      total++; if ({step_pulse, step_direction, busy, done, error} !== 5'b0) begin bad++; $display("FAIL rstmid_ctrl got=%b exp=00000", {step_pulse, step_direction, busy, done, error}); end
      total++; if ({cyl_valid, current_cyl, err_code} !== '0) begin bad++; $display("FAIL rstmid_cyl got=%0d/%b/%0d exp=0/0/0", current_cyl, cyl_valid, err_code); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_seek_uncal();
      test_recal_priority();
      test_no_motion_latency();
      test_seek_in_out();
      test_timeout();
      test_trk0_missing();
      test_abort();
      test_reset_mid_pulse();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
